// File: rtl/instr_fetch.sv
// instr_fetch: two-stage instruction fetch from a small fixed ROM.
// Stage A latches the incoming PC; stage B reads and decodes the ROM word,
// flags out-of-range addresses, detects a backwards PC step (wrap) and
// counts the valid instructions handed to the datapath.
// Stall freezes both stages. Flush empties both stages but still lets
// stage A capture the PC.
module instr_fetch #(
   parameter int                 ADDR_W  = 8,
   parameter int                 DEPTH   = 16,
   parameter int                 INSTR_W = 16,
   parameter logic [INSTR_W-1:0] NOP     = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               stall,
   input  logic               flush,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [3:0]         dst,
   output logic [7:0]         imm,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               valid,
   output logic               addr_err,
   output logic               wrap,
   output logic [7:0]         fetch_count
);

   // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   // Stage A registers
   logic [ADDR_W-1:0]  r_pc_a;
   logic               r_valid_a;

   // Stage B / output registers
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc_out;
   logic               r_valid;
   logic               r_addr_err;
   logic               r_wrap;
   logic [7:0]         r_fetch_count;

   // Wrap-detection history
   logic [ADDR_W-1:0]  r_last_pc;
   logic               r_have_last;

   logic               w_in_range;
   logic [INSTR_W-1:0] w_rom_word;
   logic               w_backwards;

   // Fixed program image; every address not listed reads as NOP.
   function automatic logic [INSTR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      logic [INSTR_W-1:0] w;
      w = NOP;
      case (a)
         ADDR_W'(0): w = INSTR_W'(16'h1005);
         ADDR_W'(1): w = INSTR_W'(16'h2103);
         ADDR_W'(2): w = INSTR_W'(16'h3210);
         ADDR_W'(3): w = INSTR_W'(16'h40FF);
         ADDR_W'(4): w = INSTR_W'(16'hF000);
         default:    w = NOP;
      endcase
      return w;
   endfunction

   // Stage B read: range check, ROM lookup and backwards-step detection.
   always_comb begin
      w_in_range  = ({1'b0, r_pc_a} < DEPTH_L);
      w_rom_word  = w_in_range ? rom_word(r_pc_a) : NOP;
      w_backwards = r_valid_a & r_have_last & (r_pc_a < r_last_pc);
   end

   // Pipeline update: reset beats flush, flush beats stall, stall holds all.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc_a        <= '0;
         r_valid_a     <= 1'b0;
         r_instr       <= NOP;
         r_pc_out      <= '0;
         r_valid       <= 1'b0;
         r_addr_err    <= 1'b0;
         r_wrap        <= 1'b0;
         r_fetch_count <= '0;
         r_last_pc     <= '0;
         r_have_last   <= 1'b0;
      end else if (flush) begin
         // Drop whatever is in flight; history and count are kept.
         r_pc_a     <= pc;
         r_valid_a  <= 1'b0;
         r_instr    <= NOP;
         r_valid    <= 1'b0;
         r_addr_err <= 1'b0;
         r_wrap     <= 1'b0;
      end else if (!stall) begin
         r_pc_a     <= pc;
         r_valid_a  <= 1'b1;
         r_instr    <= w_rom_word;
         r_pc_out   <= r_pc_a;
         r_valid    <= r_valid_a;
         r_addr_err <= r_valid_a & ~w_in_range;
         r_wrap     <= w_backwards;
         if (r_valid_a) begin
            r_last_pc     <= r_pc_a;
            r_have_last   <= 1'b1;
            r_fetch_count <= r_fetch_count + 8'd1;
         end
      end
   end

   // Outputs come straight from registers; decode fields are just slices.
   assign instr       = r_instr;
   assign opcode      = r_instr[15:12];
   assign dst         = r_instr[11:8];
   assign imm         = r_instr[7:0];
   assign pc_out      = r_pc_out;
   assign valid       = r_valid;
   assign addr_err    = r_addr_err;
   assign wrap        = r_wrap;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus for instr_fetch. Each step drives one
// cycle of inputs and queues the hand-computed output snapshot expected
// after that edge; an independent monitor pops and compares every cycle.
module tb_instr_fetch;

   // Expected snapshot: {valid, instr[15:0], pc_out[7:0], addr_err, wrap, fetch_count[7:0]}
   localparam int W = 35;

   logic        clk;
   logic        rst;
   logic [7:0]  pc;
   logic        stall;
   logic        flush;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [3:0]  dst;
   logic [7:0]  imm;
   logic [7:0]  pc_out;
   logic        valid;
   logic        addr_err;
   logic        wrap;
   logic [7:0]  fetch_count;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .stall       (stall),
      .flush       (flush),
      .instr       (instr),
      .opcode      (opcode),
      .dst         (dst),
      .imm         (imm),
      .pc_out      (pc_out),
      .valid       (valid),
      .addr_err    (addr_err),
      .wrap        (wrap),
      .fetch_count (fetch_count)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #50000;
      $display("FAIL watchdog: time %0t reached, bench did not complete", $time);
      $fatal(1, "watchdog expired");
   end

   // Driver: apply one cycle of inputs and queue the output expected after the edge.
   task automatic step(input logic r, input logic [7:0] p, input logic s, input logic f,
                       input logic v, input logic [15:0] ins, input logic [7:0] po,
                       input logic e, input logic w, input logic [7:0] c);
      rst   = r;
      pc    = p;
      stall = s;
      flush = f;
      exp_q.push_back({v, ins, po, e, w, c});
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor / scoreboard: compare the presented outputs against the queue head.
   initial begin
      logic [W-1:0]  exp_v;
      logic [W-1:0]  got_v;
      logic [15:0]   exp_ins;
      logic [15:0]   got_dec;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            cyc++;
            exp_v = exp_q.pop_front();
            got_v = {valid, instr, pc_out, addr_err, wrap, fetch_count};
            checks++;
            if (got_v === exp_v) passes++;
            else $display("FAIL cycle %0d outputs: got v=%b instr=%h pc_out=%h err=%b wrap=%b cnt=%0d, expected v=%b instr=%h pc_out=%h err=%b wrap=%b cnt=%0d",
                          cyc, got_v[34], got_v[33:18], got_v[17:10], got_v[9], got_v[8], got_v[7:0],
                          exp_v[34], exp_v[33:18], exp_v[17:10], exp_v[9], exp_v[8], exp_v[7:0]);
            exp_ins = exp_v[33:18];
            got_dec = {opcode, dst, imm};
            checks++;
            if (got_dec === exp_ins) passes++;
            else $display("FAIL cycle %0d decode: got opcode=%h dst=%h imm=%h, expected opcode=%h dst=%h imm=%h",
                          cyc, opcode, dst, imm, exp_ins[15:12], exp_ins[11:8], exp_ins[7:0]);
         end
      end
   end

   // Stimulus
   initial begin
      rst = 1'b1; pc = '0; stall = 1'b0; flush = 1'b0;

      // Reset state
      step(1, 8'd0, 0, 0,   0, 16'h0000, 8'd0, 0, 0, 8'd0);
      step(1, 8'd0, 0, 0,   0, 16'h0000, 8'd0, 0, 0, 8'd0);

      // Program-counter sequence 0,1,2,3,4,0; first valid on the 2nd edge
      step(0, 8'd0, 0, 0,   0, 16'h1005, 8'd0, 0, 0, 8'd0);
      step(0, 8'd1, 0, 0,   1, 16'h1005, 8'd0, 0, 0, 8'd1);
      step(0, 8'd2, 0, 0,   1, 16'h2103, 8'd1, 0, 0, 8'd2);
      step(0, 8'd3, 0, 0,   1, 16'h3210, 8'd2, 0, 0, 8'd3);
      step(0, 8'd4, 0, 0,   1, 16'h40FF, 8'd3, 0, 0, 8'd4);
      step(0, 8'd0, 0, 0,   1, 16'hF000, 8'd4, 0, 0, 8'd5);
      // Back to address 0: wrap pulse; then pc=3 held
      step(0, 8'd3, 0, 0,   1, 16'h1005, 8'd0, 0, 1, 8'd6);
      step(0, 8'd3, 0, 0,   1, 16'h40FF, 8'd3, 0, 0, 8'd7);
      // Equal consecutive address: no wrap
      step(0, 8'd20, 0, 0,  1, 16'h40FF, 8'd3, 0, 0, 8'd8);
      // Out-of-range address 20
      step(0, 8'd2, 0, 0,   1, 16'h0000, 8'd20, 1, 0, 8'd9);
      step(0, 8'd0, 0, 0,   1, 16'h3210, 8'd2, 0, 1, 8'd10);
      step(0, 8'd1, 0, 0,   1, 16'h1005, 8'd0, 0, 1, 8'd11);
      // Stall for 3 cycles while wrap is high; pc during the stall is ignored
      step(0, 8'd9, 1, 0,   1, 16'h1005, 8'd0, 0, 1, 8'd11);
      step(0, 8'd9, 1, 0,   1, 16'h1005, 8'd0, 0, 1, 8'd11);
      step(0, 8'd9, 1, 0,   1, 16'h1005, 8'd0, 0, 1, 8'd11);
      // Resume: address 1 then 2, 3 with nothing skipped or repeated
      step(0, 8'd2, 0, 0,   1, 16'h2103, 8'd1, 0, 0, 8'd12);
      step(0, 8'd3, 0, 0,   1, 16'h3210, 8'd2, 0, 0, 8'd13);
      step(0, 8'd4, 0, 0,   1, 16'h40FF, 8'd3, 0, 0, 8'd14);
      // Flush together with stall: outputs invalidated, pc_out and count kept
      step(0, 8'd0, 1, 1,   0, 16'h0000, 8'd3, 0, 0, 8'd14);
      // Stage A held pc=0 but invalid: ROM word appears with valid=0
      step(0, 8'd1, 0, 0,   0, 16'h1005, 8'd0, 0, 0, 8'd14);
      // Valid 2 edges after flush drops; 1 < last valid address 3 -> wrap
      step(0, 8'd2, 0, 0,   1, 16'h2103, 8'd1, 0, 1, 8'd15);
      step(0, 8'd4, 0, 0,   1, 16'h3210, 8'd2, 0, 0, 8'd16);
      // Run the count up to 200 at constant address 4
      for (int k = 17; k <= 200; k++)
         step(0, 8'd4, 0, 0, 1, 16'hF000, 8'd4, 0, 0, 8'(k));
      // Reset mid-stream: everything back to 0
      step(1, 8'd2, 0, 0,   0, 16'h0000, 8'd0, 0, 0, 8'd0);
      step(0, 8'd2, 0, 0,   0, 16'h1005, 8'd0, 0, 0, 8'd0);
      // First post-reset fetch (pc 2 < pre-reset 4) must not wrap
      step(0, 8'd3, 0, 0,   1, 16'h3210, 8'd2, 0, 0, 8'd1);
      step(0, 8'd3, 0, 0,   1, 16'h40FF, 8'd3, 0, 0, 8'd2);

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Consumer end of the program-counter interface: takes the 8-bit PC each cycle, reads the matching instruction word from an internal ROM, and presents a registered, decoded instruction to the datapath.
- Two-stage pipeline (address latch, then ROM read/decode) with stall and flush controls.
- Detects PC wrap-around (PC going backwards) and counts delivered instructions for debug.

Parameters:
- ADDR_W, 8, PC/address width
- DEPTH, 16, number of ROM words implemented; addresses >= DEPTH are out of range
- INSTR_W, 16, instruction word width
- NOP, 16'h0000, word returned for out-of-range addresses and after reset/flush

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- pc  input  ADDR_W  fetch address from the program counter
- stall  input  1  hold both pipeline stages
- flush  input  1  invalidate everything in flight
- instr  output  INSTR_W  registered instruction word
- opcode  output  4  instr[15:12]
- dst  output  4  instr[11:8]
- imm  output  8  instr[7:0]
- pc_out  output  ADDR_W  address that instr was fetched from
- valid  output  1  instr/pc_out hold a real fetched instruction
- addr_err  output  1  instr came from an out-of-range address
- wrap  output  1  one-cycle pulse: this instruction's address < the previous valid one's
- fetch_count  output  8  number of valid instructions delivered, mod 256

Behaviour:
- Reset (rst=1 at a clock edge): all internal and output registers go to 0. instr=NOP, valid=0, addr_err=0, wrap=0, fetch_count=0, pc_out=0, pc_a=0, valid_a=0, last_pc=0, have_last=0. rst overrides flush and stall.
- ROM contents are fixed:
  - 0: 16'h1005
  - 1: 16'h2103
  - 2: 16'h3210
  - 3: 16'h40FF
  - 4: 16'hF000
  - 5..DEPTH-1: NOP
- Stage A (normal cycle, no stall, no flush): pc_a <= pc; valid_a <= 1.
- Stage B (normal cycle, no stall, no flush):
  - instr <= (pc_a < DEPTH) ? rom[pc_a] : NOP
  - addr_err <= valid_a & (pc_a >= DEPTH)
  - pc_out <= pc_a
  - valid <= valid_a
- Latency: the pc value sampled at edge N appears on instr/pc_out after edge N+1. The first valid=1 occurs on the second edge after rst deasserts.
- Decoded fields (opcode, dst, imm) are pure wiring from the instr register.
- wrap: set in stage B to valid_a & have_last & (pc_a < last_pc), and 0 otherwise.
- last_pc / have_last: when a valid instruction enters stage B, last_pc <= pc_a and have_last <= 1.
- fetch_count: increments by 1 on each edge where stage B loads with valid_a=1. Wraps 255 -> 0.
- stall=1 (no flush): every register holds, including wrap and fetch_count. wrap therefore stays high for the duration of the stall if it was high; the PC presented during the stall is not sampled.
- flush=1: valid_a <= 0; valid <= 0; instr <= NOP; addr_err <= 0; wrap <= 0. pc_a still captures pc. last_pc, have_last and fetch_count are unchanged. Flush takes priority over stall.
- Following a flush, the first valid output comes 2 edges after flush deasserts.
- Equal consecutive addresses (pc_a == last_pc) do not assert wrap.

Test Plan:
- Reset, then pc cycles 0,1,2,3,4,0 (the same sequence the program counter produces) -> from the 2nd edge after reset: instr = 1005, 2103, 3210, 40FF, F000, 1005 with valid=1; wrap=1 only on the second 1005 (pc_out=0); fetch_count reaches 6.
- pc=3 stable, then observe output -> opcode=4, dst=0, imm=FF, pc_out=3.
- pc=20 (with DEPTH=16) -> instr=0000, addr_err=1, valid=1; next pc=2 -> addr_err=0, instr=3210, wrap=1.
- Streaming pc 0..4, stall=1 for 3 cycles mid-stream -> instr, pc_out, fetch_count and wrap frozen for 3 cycles; sequence resumes with no skipped or duplicated address.
- flush=1 for 1 cycle together with stall=1 -> valid=0 on the next edge, instr=0000, fetch_count unchanged, and valid returns 2 edges after flush drops.
- rst asserted mid-stream with fetch_count=200 -> after 1 edge all outputs are 0; the first fetch after reset does not assert wrap even though its pc is below the pre-reset pc.
